// File: rtl/uart_rx.sv
// Asynchronous serial receiver: 8N1-style framing (start, PAYLOAD_BITS LSB first, stop),
// mid-bit sampling from a 2-flop synchronised line, valid/frame-error strobes.
module uart_rx #(
  parameter int unsigned BIT_RATE     = 115200,
  parameter int unsigned CLK_FREQ     = 10_000_000,
  parameter int unsigned PAYLOAD_BITS = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    io_i_serial_data,
  output logic [PAYLOAD_BITS-1:0] io_o_data,
  output logic                    io_o_valid,
  output logic                    io_o_frame_err,
  output logic                    io_o_busy
);

  localparam int unsigned CPB   = CLK_FREQ / BIT_RATE;
  localparam int unsigned HALF  = CPB / 2;
  localparam int unsigned CNT_W = $clog2(CPB);
  localparam int unsigned IDX_W = $clog2(PAYLOAD_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                  state_q, state_d;
  logic                    sync1_q, rxs_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic [PAYLOAD_BITS-1:0] data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;

  // Next-state, bit timing and output strobes; all decisions use the synchronised line.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rxs_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == CNT_W'(HALF - 1)) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rxs_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == CNT_W'(CPB - 1)) begin
          cnt_d   = '0;
          shift_d = PAYLOAD_BITS'({rxs_q, shift_q} >> 1);
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(PAYLOAD_BITS - 1)) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == CNT_W'(CPB - 1)) begin
          cnt_d = '0;
          if (rxs_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_BREAK: begin
        // Hold off until the line idles so a stuck-low line cannot look like a start bit.
        cnt_d = '0;
        if (rxs_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync1_q <= io_i_serial_data;
      rxs_q   <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign io_o_data      = data_q;
  assign io_o_valid     = valid_q;
  assign io_o_frame_err = err_q;
  assign io_o_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at 10 MHz / 115200 baud, 8 data bits.
module tb_uart_rx;

  localparam int CPB = 86;

  logic       clock;
  logic       reset;
  logic       line;
  logic [7:0] data;
  logic       valid;
  logic       ferr;
  logic       busy;

  int checks;
  int fails;
  int cyc;
  int valid_cnt;
  int err_cnt;
  int excl_viol;
  int valid_cyc;
  int fall_cyc;
  logic [7:0] last_data;

  uart_rx dut (
    .clock            (clock),
    .reset            (reset),
    .io_i_serial_data (line),
    .io_o_data        (data),
    .io_o_valid       (valid),
    .io_o_frame_err   (ferr),
    .io_o_busy        (busy)
  );

  initial clock = 1'b0;
  always #50 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (valid === 1'b1) begin
      valid_cnt <= valid_cnt + 1;
      last_data <= data;
      valid_cyc <= cyc;
    end
    if (ferr === 1'b1) err_cnt <= err_cnt + 1;
    if (valid === 1'b1 && ferr === 1'b1) excl_viol <= excl_viol + 1;
  end

  task automatic drive_bit(input logic v);
    line = v;
    repeat (CPB) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    @(posedge clock);
    #1;
    fall_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    line  = 1'b1;
    reset = 1'b0;
    #120;
    checks++; if (data !== 8'h00) begin fails++; $display("FAIL reset_data got %h want 00", data); end
    checks++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", valid); end
    checks++; if (ferr !== 1'b0) begin fails++; $display("FAIL reset_ferr got %b want 0", ferr); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    @(negedge clock);
    reset = 1'b1;
    wait_cycles(10);
  endtask

  task automatic test_single;
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'h55, 1'b1);
    wait_cycles(20);
    checks++; if (valid_cnt - v0 !== 1) begin fails++; $display("FAIL single_valid_count got %0d want 1", valid_cnt - v0); end
    checks++; if (last_data !== 8'h55) begin fails++; $display("FAIL single_data got %h want 55", last_data); end
    checks++; if (data !== 8'h55) begin fails++; $display("FAIL single_data_held got %h want 55", data); end
    checks++; if (err_cnt - e0 !== 0) begin fails++; $display("FAIL single_ferr_count got %0d want 0", err_cnt - e0); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy got %b want 0", busy); end
  endtask

  task automatic test_frame_err;
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(8'hA5, 1'b0);
    repeat (3) drive_bit(1'b0);
    checks++; if (err_cnt - e0 !== 1) begin fails++; $display("FAIL ferr_count got %0d want 1", err_cnt - e0); end
    checks++; if (valid_cnt - v0 !== 0) begin fails++; $display("FAIL ferr_valid_count got %0d want 0", valid_cnt - v0); end
    checks++; if (data !== 8'h55) begin fails++; $display("FAIL ferr_data_kept got %h want 55", data); end
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL ferr_busy_held got %b want 1", busy); end
    line = 1'b1;
    wait_cycles(10);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL ferr_busy_release got %b want 0", busy); end
    wait_cycles(200);
    checks++; if (busy !== 1'b0 || err_cnt - e0 !== 1) begin
      fails++; $display("FAIL ferr_no_restart busy %b errs %0d want 0 and 1", busy, err_cnt - e0);
    end
  endtask

  task automatic test_glitch;
    int v0, e0;
    v0 = valid_cnt; e0 = err_cnt;
    @(posedge clock); #1;
    line = 1'b0;
    wait_cycles(10);
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL glitch_busy_rise got %b want 1", busy); end
    wait_cycles(10);
    line = 1'b1;
    wait_cycles(60);
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL glitch_busy_fall got %b want 0", busy); end
    checks++; if (valid_cnt - v0 !== 0) begin fails++; $display("FAIL glitch_valid got %0d want 0", valid_cnt - v0); end
    checks++; if (err_cnt - e0 !== 0) begin fails++; $display("FAIL glitch_ferr got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_back_to_back;
    int v0;
    v0 = valid_cnt;
    send_frame(8'h99, 1'b1);
    checks++; if (last_data !== 8'h99) begin fails++; $display("FAIL b2b_first_data got %h want 99", last_data); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_busy_between got %b want 0", busy); end
    send_frame(8'h00, 1'b1);
    wait_cycles(5);
    checks++; if (valid_cnt - v0 !== 2) begin fails++; $display("FAIL b2b_valid_count got %0d want 2", valid_cnt - v0); end
    checks++; if (last_data !== 8'h00) begin fails++; $display("FAIL b2b_second_data got %h want 00", last_data); end
  endtask

  task automatic test_timing;
    int lat;
    send_frame(8'hE7, 1'b1);
    wait_cycles(5);
    lat = valid_cyc - fall_cyc - 1;
    checks++; if (lat < 818 || lat > 820) begin fails++; $display("FAIL timing_latency got %0d want 819+-1", lat); end
    checks++; if (last_data !== 8'hE7) begin fails++; $display("FAIL timing_data got %h want e7", last_data); end
  endtask

  task automatic test_mid_third;
    logic [7:0] d;
    int v0;
    d  = 8'h6B;
    v0 = valid_cnt;
    @(posedge clock); #1;
    drive_bit(1'b0);
    // Each data bit is correct only in its middle third; the outer thirds carry the inverse.
    for (int i = 0; i < 8; i++) begin
      line = ~d[i]; repeat (29) @(posedge clock); #1;
      line = d[i];  repeat (29) @(posedge clock); #1;
      line = ~d[i]; repeat (28) @(posedge clock); #1;
    end
    drive_bit(1'b1);
    wait_cycles(5);
    checks++; if (valid_cnt - v0 !== 1) begin fails++; $display("FAIL midthird_valid got %0d want 1", valid_cnt - v0); end
    checks++; if (data !== 8'h6B) begin fails++; $display("FAIL midthird_data got %h want 6b", data); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    int v0, e0;
    d  = 8'h3C;
    v0 = valid_cnt; e0 = err_cnt;
    @(posedge clock); #1;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    #20;
    reset = 1'b0;
    #1;
    checks++; if (data !== 8'h00) begin fails++; $display("FAIL rstmid_data got %h want 00", data); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy got %b want 0", busy); end
    checks++; if (valid !== 1'b0 || ferr !== 1'b0) begin
      fails++; $display("FAIL rstmid_strobes valid %b ferr %b want 0 0", valid, ferr);
    end
    line = 1'b1;
    wait_cycles(5);
    reset = 1'b1;
    wait_cycles(2 * CPB);
    checks++; if (valid_cnt != v0 || err_cnt != e0) begin
      fails++; $display("FAIL rstmid_no_pulse valids %0d errs %0d want 0 0", valid_cnt - v0, err_cnt - e0);
    end
    send_frame(8'hC3, 1'b1);
    wait_cycles(5);
    checks++; if (data !== 8'hC3) begin fails++; $display("FAIL rstmid_next_data got %h want c3", data); end
    checks++; if (valid_cnt - v0 !== 1) begin fails++; $display("FAIL rstmid_next_valid got %0d want 1", valid_cnt - v0); end
  endtask

  task automatic test_exclusive;
    checks++; if (excl_viol !== 0) begin fails++; $display("FAIL exclusive_strobes got %0d want 0", excl_viol); end
  endtask

  initial begin
    checks = 0; fails = 0; cyc = 0;
    valid_cnt = 0; err_cnt = 0; excl_viol = 0; valid_cyc = 0; fall_cyc = 0;
    last_data = 8'h00;
    line = 1'b1;
    reset = 1'b1;
    test_reset;
    test_single;
    test_frame_err;
    test_glitch;
    test_back_to_back;
    test_timing;
    test_mid_third;
    test_reset_mid;
    test_exclusive;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
